// File: rtl/pool_seq_param_pkg.sv
// Shared types, default parameters and helpers for the pooling-layer sequencer.
package pool_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } pool_state_e;

  localparam int unsigned DW_DEF        = 16;
  localparam int unsigned N1_DEF        = 10;
  localparam int unsigned N2_DEF        = 15;
  localparam int unsigned OUT_LANES_DEF = 70;
  localparam int unsigned PAIRS_DEF     = 16;
  localparam int unsigned IN_AW_DEF     = 7;
  localparam int unsigned OUT_AW_DEF    = 5;
  localparam int unsigned LAT_DEF       = 4;

  // Ceiling log2, never below 1 so it is usable as a vector width.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    longint unsigned x;
    r = 0;
    x = 1;
    while (x < longint'(v)) begin
      x = x << 1;
      r = r + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/pool_seq_param_if.sv
// BRAM read/write and max-pool result bus between the sequencer and its datapath.
interface pool_seq_param_if
  import pool_pkg::*;
#(
  parameter int unsigned DW        = DW_DEF,
  parameter int unsigned N1        = N1_DEF,
  parameter int unsigned N2        = N2_DEF,
  parameter int unsigned OUT_LANES = OUT_LANES_DEF,
  parameter int unsigned IN_AW     = IN_AW_DEF,
  parameter int unsigned OUT_AW    = OUT_AW_DEF
);

  logic [N1*DW-1:0]        pool_res_1;
  logic [N2*DW-1:0]        pool_res_2;
  logic                    rd_ena;
  logic                    rd_enb;
  logic [IN_AW-1:0]        rd_addra;
  logic [IN_AW-1:0]        rd_addrb;
  logic                    wr_we;
  logic [OUT_AW-1:0]       wr_addr;
  logic [OUT_LANES*DW-1:0] wr_din;

  modport master (
    input  pool_res_1, pool_res_2,
    output rd_ena, rd_enb, rd_addra, rd_addrb, wr_we, wr_addr, wr_din
  );

  modport slave (
    output pool_res_1, pool_res_2,
    input  rd_ena, rd_enb, rd_addra, rd_addrb, wr_we, wr_addr, wr_din
  );

endinterface

// File: rtl/pool_seq_param_vld_delay.sv
// Read-valid token delay line matching the BRAM + max-tree latency; flush kills in-flight tokens.
module vld_delay #(
  parameter int unsigned LAT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic din,
  output logic dout
);

  logic [LAT-1:0] sr_q;

  if (LAT == 1) begin : g_single
    always_ff @(posedge clk) begin
      if (!rst_n || flush) sr_q <= '0;
      else                 sr_q <= din;
    end
  end else begin : g_multi
    always_ff @(posedge clk) begin
      if (!rst_n || flush) sr_q <= '0;
      else                 sr_q <= {sr_q[LAT-2:0], din};
    end
  end

  assign dout = sr_q[LAT-1];

endmodule

// File: rtl/pool_seq_param.sv
// Pooling-layer sequencer: issues paired input BRAM reads, waits for the max-pool result,
// and writes one packed, zero-padded output word per pair.
module pool_seq_param
  import pool_pkg::*;
#(
  parameter int unsigned DW        = DW_DEF,
  parameter int unsigned N1        = N1_DEF,
  parameter int unsigned N2        = N2_DEF,
  parameter int unsigned OUT_LANES = OUT_LANES_DEF,
  parameter int unsigned PAIRS     = PAIRS_DEF,
  parameter int unsigned IN_AW     = IN_AW_DEF,
  parameter int unsigned OUT_AW    = OUT_AW_DEF,
  parameter int unsigned LAT       = LAT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pool_en,
  pool_seq_param_if.master    bus,
  output logic                busy,
  output logic                finish
);

  localparam int unsigned CW = clog2(PAIRS + 1);
  localparam int unsigned OW = OUT_LANES * DW;

  localparam logic [1:0] ST_IDLE  = 2'(IDLE);
  localparam logic [1:0] ST_READ  = 2'(READ);
  localparam logic [1:0] ST_DRAIN = 2'(DRAIN);
  localparam logic [1:0] ST_DONE  = 2'(DONE);

  if ((OUT_LANES < N1 + N2) || (2 * PAIRS > 2 ** IN_AW) || (PAIRS > 2 ** OUT_AW) || (LAT == 0))
  begin : g_bad_cfg
    $fatal(1, "pool_seq_param: invalid parameter combination");
  end

  logic [1:0]        state_q, state_nxt;
  logic              pool_en_q;
  logic [CW-1:0]     rd_cnt_q, rd_cnt_nxt;
  logic [CW-1:0]     wr_cnt_q, wr_cnt_nxt;
  logic              rd_en_q, rd_en_nxt;
  logic [IN_AW-1:0]  rd_addra_q, rd_addra_nxt;
  logic [IN_AW-1:0]  rd_addrb_q, rd_addrb_nxt;
  logic              wr_we_q, wr_we_nxt;
  logic [OUT_AW-1:0] wr_addr_q, wr_addr_nxt;
  logic [OW-1:0]     wr_din_q, wr_din_nxt;
  logic              busy_nxt, finish_nxt;
  logic              active_c, abort_c, vld_tail_c;

  vld_delay #(.LAT(LAT)) u_vld_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (abort_c),
    .din   (rd_en_q),
    .dout  (vld_tail_c)
  );

  // Next-state, read issue and write packing.
  always_comb begin
    state_nxt    = state_q;
    rd_cnt_nxt   = rd_cnt_q;
    wr_cnt_nxt   = wr_cnt_q;
    rd_en_nxt    = 1'b0;
    rd_addra_nxt = rd_addra_q;
    rd_addrb_nxt = rd_addrb_q;
    wr_we_nxt    = 1'b0;
    wr_addr_nxt  = wr_addr_q;
    wr_din_nxt   = wr_din_q;
    active_c     = (state_q == ST_READ) || (state_q == ST_DRAIN);
    abort_c      = active_c && !pool_en;

    case (state_q)
      ST_IDLE: begin
        if (pool_en && !pool_en_q) begin
          state_nxt  = ST_READ;
          rd_cnt_nxt = '0;
          wr_cnt_nxt = '0;
        end
      end
      ST_READ: begin
        if (!pool_en)                        state_nxt = ST_IDLE;
        else if (rd_cnt_q == CW'(PAIRS))     state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!pool_en)                        state_nxt = ST_IDLE;
        else if (wr_cnt_q == CW'(PAIRS))     state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (!pool_en)                        state_nxt = ST_IDLE;
      end
      default:                               state_nxt = ST_IDLE;
    endcase

    if (state_nxt == ST_READ) begin
      rd_en_nxt    = 1'b1;
      rd_addra_nxt = IN_AW'({rd_cnt_nxt, 1'b0});
      rd_addrb_nxt = IN_AW'({rd_cnt_nxt, 1'b1});
      rd_cnt_nxt   = rd_cnt_nxt + CW'(1);
    end

    // Capture the pool result on the cycle its valid token leaves the delay line.
    if (active_c && !abort_c && vld_tail_c) begin
      wr_we_nxt   = 1'b1;
      wr_addr_nxt = OUT_AW'(wr_cnt_q);
      wr_din_nxt  = OW'({bus.pool_res_1, bus.pool_res_2});
      wr_cnt_nxt  = wr_cnt_q + CW'(1);
    end

    busy_nxt   = (state_nxt == ST_READ) || (state_nxt == ST_DRAIN);
    finish_nxt = (state_nxt == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pool_en_q  <= 1'b0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      rd_en_q    <= 1'b0;
      rd_addra_q <= '0;
      rd_addrb_q <= '0;
      wr_we_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_din_q   <= '0;
      busy       <= 1'b0;
      finish     <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      pool_en_q  <= pool_en;
      rd_cnt_q   <= rd_cnt_nxt;
      wr_cnt_q   <= wr_cnt_nxt;
      rd_en_q    <= rd_en_nxt;
      rd_addra_q <= rd_addra_nxt;
      rd_addrb_q <= rd_addrb_nxt;
      wr_we_q    <= wr_we_nxt;
      wr_addr_q  <= wr_addr_nxt;
      wr_din_q   <= wr_din_nxt;
      busy       <= busy_nxt;
      finish     <= finish_nxt;
    end
  end

  assign bus.rd_ena   = rd_en_q;
  assign bus.rd_enb   = rd_en_q;
  assign bus.rd_addra = rd_addra_q;
  assign bus.rd_addrb = rd_addrb_q;
  assign bus.wr_we    = wr_we_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_din   = wr_din_q;

endmodule

// File: tb/tb_pool_seq_param.sv
// Directed bench for pool_seq_param: default configuration plus a small LAT=1 instance.
module tb_pool_seq_param;

  localparam int DW     = 16;
  localparam int N1     = 10;
  localparam int N2     = 15;
  localparam int OL     = 70;
  localparam int PAIRS  = 16;
  localparam int IN_AW  = 7;
  localparam int OUT_AW = 5;
  localparam int LAT    = 4;

  localparam int N1S     = 2;
  localparam int N2S     = 2;
  localparam int OLS     = 4;
  localparam int PAIRSS  = 4;
  localparam int IN_AWS  = 3;
  localparam int OUT_AWS = 2;
  localparam int LATS    = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pool_en0 = 1'b0;
  logic pool_en5 = 1'b0;
  logic busy0, finish0, busy5, finish5;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  pool_seq_param_if #(.DW(DW), .N1(N1), .N2(N2), .OUT_LANES(OL), .IN_AW(IN_AW),
                      .OUT_AW(OUT_AW)) bus0 ();
  pool_seq_param_if #(.DW(DW), .N1(N1S), .N2(N2S), .OUT_LANES(OLS), .IN_AW(IN_AWS),
                      .OUT_AW(OUT_AWS)) bus5 ();

  pool_seq_param #(.DW(DW), .N1(N1), .N2(N2), .OUT_LANES(OL), .PAIRS(PAIRS),
                   .IN_AW(IN_AW), .OUT_AW(OUT_AW), .LAT(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n), .pool_en(pool_en0), .bus(bus0.master),
    .busy(busy0), .finish(finish0));

  pool_seq_param #(.DW(DW), .N1(N1S), .N2(N2S), .OUT_LANES(OLS), .PAIRS(PAIRSS),
                   .IN_AW(IN_AWS), .OUT_AW(OUT_AWS), .LAT(LATS)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .pool_en(pool_en5), .bus(bus5.master),
    .busy(busy5), .finish(finish5));

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [15:0] r1_val(input int mode, input int c, input int i);
    return (mode == 0) ? 16'(i + 1) : 16'(32'h4000 + c * 32 + i);
  endfunction

  function automatic logic [15:0] r2_val(input int mode, input int c, input int j);
    return (mode == 0) ? 16'(32'h100 + j) : 16'(32'hA000 + c * 32 + j);
  endfunction

  task automatic drive_res0(input int mode, input int c);
    for (int i = 0; i < N1; i++) bus0.pool_res_1[i*DW +: DW] = r1_val(mode, c, i);
    for (int j = 0; j < N2; j++) bus0.pool_res_2[j*DW +: DW] = r2_val(mode, c, j);
  endtask

  function automatic logic [1279:0] exp_din0(input int mode, input int c);
    logic [1279:0] v;
    v = '0;
    for (int j = 0; j < N2; j++) v[j*DW +: DW] = r2_val(mode, c, j);
    for (int i = 0; i < N1; i++) v[(N2+i)*DW +: DW] = r1_val(mode, c, i);
    return v;
  endfunction

  task automatic check_din0(input string tag, input logic [1279:0] ex);
    logic [1279:0] ob;
    ob = 1280'(bus0.wr_din);
    for (int k = 0; k < 5; k++)
      check_eq($sformatf("%s wr_din chunk%0d", tag, k), ob[k*256 +: 256], ex[k*256 +: 256]);
  endtask

  task automatic drive_res5(input int c);
    for (int i = 0; i < N1S; i++) bus5.pool_res_1[i*DW +: DW] = 16'(32'h1000 + c * 16 + i);
    for (int j = 0; j < N2S; j++) bus5.pool_res_2[j*DW +: DW] = 16'(32'h2000 + c * 16 + j);
  endtask

  // Full default layer from a fresh rising edge; expected trace written from the timing rules.
  task automatic run_layer0(input int mode);
    logic [OL*DW-1:0] w;
    bit rd, wr;
    pool_en0 = 1'b1;
    cyc = 0;
    drive_res0(mode, 0);
    for (int c = 1; c <= 22; c++) begin
      tick();
      drive_res0(mode, c);
      rd = (c >= 1) && (c <= 16);
      wr = (c >= 6) && (c <= 21);
      check_eq($sformatf("m%0d c%0d rd_ena", mode, c), 256'(bus0.rd_ena), 256'(rd));
      check_eq($sformatf("m%0d c%0d rd_enb", mode, c), 256'(bus0.rd_enb), 256'(rd));
      if (rd) begin
        check_eq($sformatf("m%0d c%0d rd_addra", mode, c), 256'(bus0.rd_addra), 256'(2*(c-1)));
        check_eq($sformatf("m%0d c%0d rd_addrb", mode, c), 256'(bus0.rd_addrb), 256'(2*c-1));
      end
      check_eq($sformatf("m%0d c%0d wr_we", mode, c), 256'(bus0.wr_we), 256'(wr));
      if (wr) begin
        check_eq($sformatf("m%0d c%0d wr_addr", mode, c), 256'(bus0.wr_addr), 256'(c-6));
        check_din0($sformatf("m%0d c%0d", mode, c), exp_din0(mode, c - 1));
      end
      if (mode == 0 && c == 6) begin
        w = bus0.wr_din;
        check_eq("lane0",  256'(w[0*DW +: DW]),  256'(16'h0100));
        check_eq("lane14", 256'(w[14*DW +: DW]), 256'(16'h010E));
        check_eq("lane15", 256'(w[15*DW +: DW]), 256'(16'h0001));
        check_eq("lane24", 256'(w[24*DW +: DW]), 256'(16'h000A));
        check_eq("lane25", 256'(w[25*DW +: DW]), 256'(16'h0000));
        check_eq("lane69", 256'(w[69*DW +: DW]), 256'(16'h0000));
      end
      check_eq($sformatf("m%0d c%0d busy", mode, c), 256'(busy0), 256'(c <= 21));
      check_eq($sformatf("m%0d c%0d finish", mode, c), 256'(finish0), 256'(c == 22));
    end
  endtask

  initial begin
    drive_res0(0, 0);
    drive_res5(0);

    // Reset state.
    rst_n = 1'b0;
    repeat (3) tick();
    check_eq("rst rd_ena", 256'(bus0.rd_ena), 256'(0));
    check_eq("rst rd_addra", 256'(bus0.rd_addra), 256'(0));
    check_eq("rst wr_we", 256'(bus0.wr_we), 256'(0));
    check_eq("rst wr_din", 256'(bus0.wr_din), 256'(0));
    check_eq("rst busy", 256'(busy0), 256'(0));
    check_eq("rst finish", 256'(finish0), 256'(0));
    check_eq("rst busy5", 256'(busy5), 256'(0));
    rst_n = 1'b1;
    tick();
    tick();
    check_eq("idle rd_ena", 256'(bus0.rd_ena), 256'(0));
    check_eq("idle busy", 256'(busy0), 256'(0));

    // Constant lane pattern, then held enable in DONE.
    run_layer0(0);
    for (int c = 23; c <= 30; c++) begin
      tick();
      check_eq($sformatf("hold c%0d finish", c), 256'(finish0), 256'(1));
      check_eq($sformatf("hold c%0d busy", c), 256'(busy0), 256'(0));
      check_eq($sformatf("hold c%0d rd_ena", c), 256'(bus0.rd_ena), 256'(0));
      check_eq($sformatf("hold c%0d wr_we", c), 256'(bus0.wr_we), 256'(0));
    end
    pool_en0 = 1'b0;
    tick();
    check_eq("drop finish", 256'(finish0), 256'(0));
    check_eq("drop busy", 256'(busy0), 256'(0));
    tick();

    // Second layer with cycle-dependent results.
    run_layer0(1);
    pool_en0 = 1'b0;
    tick();
    tick();

    // Abort mid-READ, then restart from address 0.
    pool_en0 = 1'b1;
    cyc = 0;
    drive_res0(0, 0);
    for (int c = 1; c <= 8; c++) begin
      tick();
      drive_res0(0, c);
      check_eq($sformatf("ab c%0d rd_ena", c), 256'(bus0.rd_ena), 256'(1));
      check_eq($sformatf("ab c%0d rd_addra", c), 256'(bus0.rd_addra), 256'(2*(c-1)));
    end
    pool_en0 = 1'b0;
    for (int c = 9; c <= 25; c++) begin
      tick();
      drive_res0(0, c);
      check_eq($sformatf("ab c%0d rd_ena", c), 256'(bus0.rd_ena), 256'(0));
      if (c >= 10) check_eq($sformatf("ab c%0d wr_we", c), 256'(bus0.wr_we), 256'(0));
      check_eq($sformatf("ab c%0d busy", c), 256'(busy0), 256'(0));
      check_eq($sformatf("ab c%0d finish", c), 256'(finish0), 256'(0));
    end
    run_layer0(0);
    pool_en0 = 1'b0;
    tick();
    tick();

    // Reset during DRAIN.
    pool_en0 = 1'b1;
    cyc = 0;
    drive_res0(0, 0);
    for (int c = 1; c <= 18; c++) begin
      tick();
      drive_res0(0, c);
    end
    check_eq("dr busy", 256'(busy0), 256'(1));
    check_eq("dr rd_ena", 256'(bus0.rd_ena), 256'(0));
    check_eq("dr wr_we", 256'(bus0.wr_we), 256'(1));
    check_eq("dr wr_addr", 256'(bus0.wr_addr), 256'(12));
    rst_n = 1'b0;
    pool_en0 = 1'b0;
    tick();
    check_eq("drst rd_ena", 256'(bus0.rd_ena), 256'(0));
    check_eq("drst rd_enb", 256'(bus0.rd_enb), 256'(0));
    check_eq("drst rd_addra", 256'(bus0.rd_addra), 256'(0));
    check_eq("drst rd_addrb", 256'(bus0.rd_addrb), 256'(0));
    check_eq("drst wr_we", 256'(bus0.wr_we), 256'(0));
    check_eq("drst wr_addr", 256'(bus0.wr_addr), 256'(0));
    check_din0("drst", '0);
    check_eq("drst busy", 256'(busy0), 256'(0));
    check_eq("drst finish", 256'(finish0), 256'(0));
    check_eq("drst state", 256'(u_dut.state_q), 256'(0));
    rst_n = 1'b1;
    for (int c = 20; c <= 30; c++) begin
      tick();
      check_eq($sformatf("post c%0d wr_we", c), 256'(bus0.wr_we), 256'(0));
      check_eq($sformatf("post c%0d rd_ena", c), 256'(bus0.rd_ena), 256'(0));
      check_eq($sformatf("post c%0d busy", c), 256'(busy0), 256'(0));
      check_eq($sformatf("post c%0d finish", c), 256'(finish0), 256'(0));
    end

    // Small instance: LAT=1, PAIRS=4, no pad lanes.
    pool_en5 = 1'b1;
    cyc = 0;
    drive_res5(0);
    for (int c = 1; c <= 9; c++) begin
      logic [63:0] ex;
      bit rd, wr;
      tick();
      drive_res5(c);
      rd = (c >= 1) && (c <= 4);
      wr = (c >= 3) && (c <= 6);
      check_eq($sformatf("s c%0d rd_ena", c), 256'(bus5.rd_ena), 256'(rd));
      if (rd) check_eq($sformatf("s c%0d rd_addra", c), 256'(bus5.rd_addra), 256'(2*(c-1)));
      check_eq($sformatf("s c%0d wr_we", c), 256'(bus5.wr_we), 256'(wr));
      if (wr) begin
        ex = {16'(32'h1000 + (c-1)*16 + 1), 16'(32'h1000 + (c-1)*16),
              16'(32'h2000 + (c-1)*16 + 1), 16'(32'h2000 + (c-1)*16)};
        check_eq($sformatf("s c%0d wr_addr", c), 256'(bus5.wr_addr), 256'(c-3));
        check_eq($sformatf("s c%0d wr_din", c), 256'(bus5.wr_din), 256'(ex));
      end
      check_eq($sformatf("s c%0d busy", c), 256'(busy5), 256'(c <= 6));
      check_eq($sformatf("s c%0d finish", c), 256'(finish5), 256'(c >= 7));
    end
    pool_en5 = 1'b0;
    tick();
    check_eq("s drop finish", 256'(finish5), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

endmodule
